serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition controller that time-shares one external 1-bit full-adder cell (inputs A, B, C; outputs SUM, Carry) to add two WIDTH-bit operands, LSB first, one bit per clock. It accepts a start request and sequences operand bits into the cell. It feeds the cell's carry back through a carry register, assembles the result word and signals completion with a one-cycle pulse. It sits between the operand source and the shared full-adder instance.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  reset, one clock; reset is synchronous and active-high
- START  input  1  request; sampled only in IDLE or DONE state
- A_IN  input  WIDTH  operand A, latched on accepted START
- B_IN  input  WIDTH  operand B, latched on accepted START
- CIN  input  1  carry-in, latched on accepted START
- FA_A  output  1  to full-adder A input
- FA_B  output  1  to full-adder B input
- FA_C  output  1  to full-adder C (carry-in) input
- FA_SUM  input  1  from full-adder SUM
- FA_CARRY  input  1  from full-adder Carry
- BUSY  output  1  high while in RUN
- DONE  output  1  one-cycle completion pulse
- SUM_OUT  output  WIDTH  result word, held until next completion
- COUT  output  1  final carry-out, held until next completion

## Operation
- States: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE or DONE with START=1 triggers acceptance:
  - latch A_IN and B_IN into shift registers;
  - load the carry register with CIN;
  - clear the bit counter;
  - go to RUN.
- DONE with START=0 goes to IDLE.
- IDLE with START=0 stays in IDLE.
- RUN, each cycle:
  - FA_A = A shift reg bit 0; FA_B = B shift reg bit 0; FA_C = carry register. These are driven directly from registers, with no logic on the START path.
  - On the edge, FA_SUM shifts into the result shift register MSB, and the carry register takes FA_CARRY.
  - The A and B shift registers shift right, and the counter increments.
  - When the counter equals WIDTH-1 on that edge, the controller copies the result shift register (including the current FA_SUM) to SUM_OUT, copies FA_CARRY to COUT and moves to DONE.
- START during RUN is ignored; there is no queueing.
- Arithmetic: SUM_OUT = (A_IN + B_IN + CIN) mod 2^WIDTH; COUT = bit WIDTH of the full sum.
- FA_A, FA_B and FA_C are 0 in IDLE and DONE.
- Reset, including mid-RUN, takes effect at the next edge:
  - state goes to IDLE;
  - BUSY=0, DONE=0, SUM_OUT=0, COUT=0 (and OVF=0 when configured);
  - all shift, carry and counter registers are cleared;
  - an aborted operation never pulses DONE.

## Timing
- START accepted at edge 0. Bit i is presented on FA_* during the cycle between edge i and edge i+1, and captured at edge i+1 (i = 0..WIDTH-1).
- BUSY is high from edge 0 to edge WIDTH. SUM_OUT and COUT update at edge WIDTH. DONE is high for exactly the cycle between edge WIDTH and edge WIDTH+1.
- Latency is WIDTH+1 edges from START sample to the DONE deassert edge.
- Back-to-back: START high during the DONE cycle is accepted at edge WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- The external cell is combinational. FA_SUM and FA_CARRY must settle within one CLK period; the gate delays (a few units) are far below the clock period.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - adds output OVF (1 bit), the two's-complement overflow;
  - OVF = (carry into MSB) XOR COUT, where the carry into MSB is the carry register value during bit WIDTH-1;
  - OVF is registered at edge WIDTH with SUM_OUT, held until the next completion, and reset to 0.
- SERIAL_ADDER_OVF_EN undefined: no OVF port and no related logic.

## Test plan
All scenarios use WIDTH=8, with the full-adder cell instantiated on the FA_* ports.
- Reset: RST=1 for 2 edges with random inputs. Required: BUSY=0, DONE=0, SUM_OUT=0x00, COUT=0, FA_A, FA_B, FA_C all 0.
- A_IN=0x35, B_IN=0x4A, CIN=0, START pulse. Required: BUSY for 8 cycles; DONE pulse after edge 8; SUM_OUT=0x7F, COUT=0 (OVF=0).
- A_IN=0xFF, B_IN=0x01, CIN=0. Required: SUM_OUT=0x00, COUT=1, OVF=0. Check per-bit FA_C sequence 0,1,1,1,1,1,1,1.
- A_IN=0x7F, B_IN=0x00, CIN=1. Required: SUM_OUT=0x80, COUT=0, OVF=1.
- Held START:
  - hold START=1 throughout, changing A_IN and B_IN mid-RUN;
  - required: the first result uses only the edge-0 operands;
  - the second operation is accepted in the DONE cycle;
  - DONE pulses at edge 8 and edge 17.
- A_IN=0xAA, B_IN=0x55, CIN=1, with RST=1 at edge 4. Required: IDLE at edge 5, no DONE pulse, SUM_OUT=0x00, COUT=0.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bus between the operand source (master) and the
// bit-serial adder controller (slave).
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf result bit.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum_out, cout, ovf
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum_out, cout, ovf
  );
`else
  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum_out, cout
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum_out, cout
  );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition controller. Time-shares one external combinational
// full-adder cell: operands are presented LSB first, one bit per clock, the
// cell's carry is fed back through r_carry, and the result word is assembled
// in a shift register and published with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered
// two's-complement overflow flag (bus.ovf).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  serial_adder_ctrl_if.slave         bus,
  output logic                       o_fa_a,
  output logic                       o_fa_b,
  output logic                       o_fa_c,
  input  logic                       i_fa_sum,
  input  logic                       i_fa_carry
);

  localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  // START is only honoured outside RUN; the last bit is the one with cnt == WIDTH-1.
  assign w_accept   = bus.start && (r_state != S_RUN);
  assign w_last     = (r_state == S_RUN) && (r_cnt == LAST);
  // Current FA_SUM enters at the MSB while older bits move toward the LSB.
  assign w_res_next = {i_fa_sum, {(WIDTH-1){1'b0}}} | (r_res_sr >> 1);

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/result shifting, carry feedback, bit counting and result publication.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: datapath registers are cleared explicitly; an aborted operation must leave no residue.
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_res_sr  <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_sum_out <= '0;
      r_cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a_sr   <= bus.a_in;
      r_b_sr   <= bus.b_in;
      r_res_sr <= '0;
      r_carry  <= bus.cin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_res_sr <= w_res_next;
      r_carry  <= i_fa_carry;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum_out <= w_res_next;
        r_cout    <= i_fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
        // r_carry still holds the carry into the MSB during the last bit.
        r_ovf     <= r_carry ^ i_fa_carry;
`endif
      end
    end
  end

  // Cell inputs come straight from registers, forced low outside RUN.
  assign o_fa_a = (r_state == S_RUN) & r_a_sr[0];
  assign o_fa_b = (r_state == S_RUN) & r_b_sr[0];
  assign o_fa_c = (r_state == S_RUN) & r_carry;

  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = (r_state == S_DONE);
  assign bus.sum_out = r_sum_out;
  assign bus.cout    = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf     = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed-vector bench for serial_adder_ctrl with a behavioural full-adder
// cell on the FA_* ports. Inputs are driven and outputs sampled on the
// falling clock edge. Define SERIAL_ADDER_OVF_EN to also check ovf.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic fa_a, fa_b, fa_c, fa_sum, fa_carry;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  // External combinational full-adder cell.
  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_fa_a     (fa_a),
    .o_fa_b     (fa_b),
    .o_fa_c     (fa_c),
    .i_fa_sum   (fa_sum),
    .i_fa_carry (fa_carry)
  );

  function automatic logic get_ovf();
`ifdef SERIAL_ADDER_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Runs one operation from an idle controller and returns what was observed.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output logic [7:0] sum, output logic cout, output logic ovf,
                       output logic [7:0] a_seq, output logic [7:0] b_seq,
                       output logic [7:0] c_seq, output int busy_cycles,
                       output int done_in_run, output logic done_end,
                       output logic busy_end, output logic done_after);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.cin   = cin;
    @(negedge clk);
    bus.start   = 1'b0;
    busy_cycles = 0;
    done_in_run = 0;
    for (int i = 0; i < WIDTH; i++) begin
      a_seq[i] = fa_a;
      b_seq[i] = fa_b;
      c_seq[i] = fa_c;
      if (bus.busy) busy_cycles++;
      if (bus.done) done_in_run++;
      @(negedge clk);
    end
    done_end = bus.done;
    busy_end = bus.busy;
    sum      = bus.sum_out;
    cout     = bus.cout;
    ovf      = get_ovf();
    @(negedge clk);
    done_after = bus.done;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'($urandom);
    bus.a_in  = 8'($urandom);
    bus.b_in  = 8'($urandom);
    bus.cin   = 1'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.sum_out !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", bus.sum_out); end
    checks++; if (bus.cout !== 1'b0)     begin failures++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
    checks++; if ({fa_a, fa_b, fa_c} !== 3'b000) begin failures++; $display("FAIL reset_fa got=%b exp=000", {fa_a, fa_b, fa_c}); end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] sum, a_seq, b_seq, c_seq;
    logic cout, ovf, done_end, busy_end, done_after;
    int busy_cycles, done_in_run;
    do_op(8'h35, 8'h4A, 1'b0, sum, cout, ovf, a_seq, b_seq, c_seq,
          busy_cycles, done_in_run, done_end, busy_end, done_after);
    checks++; if (sum !== 8'h7F)     begin failures++; $display("FAIL basic_sum got=%h exp=7f", sum); end
    checks++; if (cout !== 1'b0)     begin failures++; $display("FAIL basic_cout got=%b exp=0", cout); end
    checks++; if (busy_cycles != 8)  begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", busy_cycles); end
    checks++; if (done_in_run != 0)  begin failures++; $display("FAIL basic_early_done got=%0d exp=0", done_in_run); end
    checks++; if (done_end !== 1'b1) begin failures++; $display("FAIL basic_done_edge8 got=%b exp=1", done_end); end
    checks++; if (busy_end !== 1'b0) begin failures++; $display("FAIL basic_busy_edge8 got=%b exp=0", busy_end); end
    checks++; if (done_after !== 1'b0) begin failures++; $display("FAIL basic_done_edge9 got=%b exp=0", done_after); end
    checks++; if (a_seq !== 8'h35)   begin failures++; $display("FAIL basic_fa_a_seq got=%h exp=35", a_seq); end
    checks++; if (b_seq !== 8'h4A)   begin failures++; $display("FAIL basic_fa_b_seq got=%h exp=4a", b_seq); end
    checks++; if (c_seq !== 8'h00)   begin failures++; $display("FAIL basic_fa_c_seq got=%h exp=00", c_seq); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0)      begin failures++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
`endif
  endtask

  task automatic test_carry_chain();
    logic [7:0] sum, a_seq, b_seq, c_seq;
    logic cout, ovf, done_end, busy_end, done_after;
    int busy_cycles, done_in_run;
    do_op(8'hFF, 8'h01, 1'b0, sum, cout, ovf, a_seq, b_seq, c_seq,
          busy_cycles, done_in_run, done_end, busy_end, done_after);
    checks++; if (sum !== 8'h00)     begin failures++; $display("FAIL chain_sum got=%h exp=00", sum); end
    checks++; if (cout !== 1'b1)     begin failures++; $display("FAIL chain_cout got=%b exp=1", cout); end
    // FA_C per bit 0,1,1,1,1,1,1,1 (bit i of c_seq is bit i's carry-in).
    checks++; if (c_seq !== 8'hFE)   begin failures++; $display("FAIL chain_fa_c_seq got=%h exp=fe", c_seq); end
    checks++; if (done_end !== 1'b1) begin failures++; $display("FAIL chain_done got=%b exp=1", done_end); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0)      begin failures++; $display("FAIL chain_ovf got=%b exp=0", ovf); end
`endif
  endtask

  task automatic test_overflow();
    logic [7:0] sum, a_seq, b_seq, c_seq;
    logic cout, ovf, done_end, busy_end, done_after;
    int busy_cycles, done_in_run;
    do_op(8'h7F, 8'h00, 1'b1, sum, cout, ovf, a_seq, b_seq, c_seq,
          busy_cycles, done_in_run, done_end, busy_end, done_after);
    checks++; if (sum !== 8'h80)     begin failures++; $display("FAIL ovf_sum got=%h exp=80", sum); end
    checks++; if (cout !== 1'b0)     begin failures++; $display("FAIL ovf_cout got=%b exp=0", cout); end
    checks++; if (c_seq !== 8'hFF)   begin failures++; $display("FAIL ovf_fa_c_seq got=%h exp=ff", c_seq); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b1)      begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [18:0] done_seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 8'h12;
    bus.b_in  = 8'h34;
    bus.cin   = 1'b0;
    done_seen = '0;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      done_seen[k] = bus.done;
      if (k == 3) begin
        bus.a_in = 8'h56;
        bus.b_in = 8'h21;
      end
      if (k == 8) begin
        checks++; if (bus.sum_out !== 8'h46) begin failures++; $display("FAIL b2b_first_sum got=%h exp=46", bus.sum_out); end
      end
      if (k == 9) begin
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_second_busy got=%b exp=1", bus.busy); end
      end
      if (k == 17) begin
        checks++; if (bus.sum_out !== 8'h77) begin failures++; $display("FAIL b2b_second_sum got=%h exp=77", bus.sum_out); end
        bus.start = 1'b0;
      end
      if (k == 18) begin
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {bus.busy, bus.done}); end
      end
    end
    checks++; if (done_seen !== 19'h20100) begin failures++; $display("FAIL b2b_done_edges got=%h exp=20100", done_seen); end
  endtask

  task automatic test_reset_mid_run();
    int done_count;
    done_count = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 8'hAA;
    bus.b_in  = 8'h55;
    bus.cin   = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (bus.done) done_count++;
      if (k == 0) bus.start = 1'b0;
      if (k == 4) begin
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", bus.busy); end
        rst = 1'b1;
      end
      if (k == 5) begin
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin failures++; $display("FAIL abort_idle got=%b exp=00", {bus.busy, bus.done}); end
        checks++; if (bus.sum_out !== 8'h00) begin failures++; $display("FAIL abort_sum got=%h exp=00", bus.sum_out); end
        checks++; if (bus.cout !== 1'b0) begin failures++; $display("FAIL abort_cout got=%b exp=0", bus.cout); end
        checks++; if ({fa_a, fa_b, fa_c} !== 3'b000) begin failures++; $display("FAIL abort_fa got=%b exp=000", {fa_a, fa_b, fa_c}); end
        rst = 1'b0;
      end
    end
    checks++; if (done_count != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_count); end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.cin   = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
